// File: rtl/lzc_pkg.sv
// lzc_pkg: shared constants, types and the index-to-one-hot reference function for the LZC path.
package lzc_pkg;
    localparam int LZC_WIDTH = 32;
    localparam int LZC_IDX_W = 6;

    typedef logic [LZC_IDX_W-1:0] lzc_idx_t;

    typedef enum logic {IDLE, ACCUM} lzc_asm_state_e;

    function automatic logic [LZC_WIDTH-1:0] lzc_idx2onehot(input lzc_idx_t idx);
        logic [LZC_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LZC_WIDTH; i++) r[LZC_WIDTH-1-i] = (idx == LZC_IDX_W'(i));
        return r;
    endfunction
endpackage

// File: rtl/lzc_idx_decode.sv
// lzc_idx_decode: MSB-relative index to one-hot; indices >= WIDTH decode to zero.
module lzc_idx_decode #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign onehot[WIDTH-1-i] = (idx == IDX_W'(i));
    end
endmodule

// File: rtl/lzc_word_assembler.sv
// lzc_word_assembler: OR-accumulates index beats into words with a valid/ready output.
// Defining LZC_ORDER_CHECK_EN adds out_order_err for non-strictly-increasing index streams.
module lzc_word_assembler
    import lzc_pkg::*;
#(
    parameter int WIDTH = LZC_WIDTH,
    parameter int IDX_W = LZC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [IDX_W-1:0] out_beats,
    output logic             out_dup
`ifdef LZC_ORDER_CHECK_EN
    ,
    output logic             out_order_err
`endif
);
    lzc_asm_state_e   state, state_nxt;
    logic [WIDTH-1:0] acc, dec, word_nxt;
    logic [IDX_W-1:0] acc_beats, beats_nxt;
    logic             acc_dup, dup_nxt, fire;

    lzc_idx_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (.idx(in_idx), .onehot(dec));

    assign in_ready  = ~out_valid | out_ready;
    assign fire      = in_valid & in_ready;
    assign word_nxt  = acc | dec;
    assign beats_nxt = (acc_beats == '1) ? acc_beats : acc_beats + 1'b1;
    assign dup_nxt   = acc_dup | (|(acc & dec));

    always_comb begin
        state_nxt = state;
        if (fire) state_nxt = in_last ? IDLE : ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            acc_beats <= '0;
            acc_dup   <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_beats <= '0;
            out_dup   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                acc       <= in_last ? '0 : word_nxt;
                acc_beats <= in_last ? '0 : beats_nxt;
                acc_dup   <= ~in_last & dup_nxt;
            end
            if (fire & in_last) begin
                out_valid <= 1'b1;
                out_word  <= word_nxt;
                out_beats <= beats_nxt;
                out_dup   <= dup_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef LZC_ORDER_CHECK_EN
    // Out-of-range indices clamp to WIDTH, so a WIDTH beat after anything compares as non-increasing.
    logic [IDX_W-1:0] idx_c, prev_idx;
    logic             acc_err, err_nxt;

    assign idx_c   = (in_idx >= IDX_W'(WIDTH)) ? IDX_W'(WIDTH) : in_idx;
    assign err_nxt = acc_err | ((state == ACCUM) & ((idx_c <= prev_idx) | (idx_c == IDX_W'(WIDTH))));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_idx      <= '0;
            acc_err       <= 1'b0;
            out_order_err <= 1'b0;
        end else if (fire) begin
            prev_idx <= idx_c;
            acc_err  <= ~in_last & err_nxt;
            if (in_last) out_order_err <= err_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_lzc_word_assembler.sv
// tb_lzc_word_assembler: table-driven vectors plus backpressure, saturation and reset sequences.
module tb_lzc_word_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_idx = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [5:0]  out_beats;
    logic        out_dup;
`ifdef LZC_ORDER_CHECK_EN
    logic        out_order_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    lzc_word_assembler dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_beats(out_beats), .out_dup(out_dup)
`ifdef LZC_ORDER_CHECK_EN
        , .out_order_err(out_order_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    typedef struct {
        string       name;
        int          n;
        logic [47:0] idx;
        logic [31:0] word;
        logic [5:0]  beats;
        logic        dup;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [5:0] idx, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_idx   = idx;
        in_last  = last;
        while (!in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"single_idx0", 1, 48'(6'd0),                      32'h8000_0000, 6'd1, 1'b0, 1'b0};
        tbl[1] = '{"multi_3_5_31", 3, 48'({6'd31, 6'd5, 6'd3}),      32'h1400_0001, 6'd3, 1'b0, 1'b0};
        tbl[2] = '{"empty_32",    1, 48'(6'd32),                     32'h0000_0000, 6'd1, 1'b0, 1'b0};
        tbl[3] = '{"oor_63",      1, 48'(6'd63),                     32'h0000_0000, 6'd1, 1'b0, 1'b0};
        tbl[4] = '{"dup_7_7",     2, 48'({6'd7, 6'd7}),              32'h0100_0000, 6'd2, 1'b1, 1'b1};
        tbl[5] = '{"msb_lsb",     2, 48'({6'd31, 6'd0}),             32'h8000_0001, 6'd2, 1'b0, 1'b0};
        tbl[6] = '{"dup_2_9_2",   3, 48'({6'd2, 6'd9, 6'd2}),        32'h2040_0000, 6'd3, 1'b1, 1'b1};
        tbl[7] = '{"none_then_31", 2, 48'({6'd31, 6'd32}),           32'h0000_0001, 6'd2, 1'b0, 1'b1};
        tbl[8] = '{"order_5_3",   2, 48'({6'd3, 6'd5}),              32'h1400_0000, 6'd2, 1'b0, 1'b1};
        tbl[9] = '{"order_3_5",   2, 48'({6'd5, 6'd3}),              32'h1400_0000, 6'd2, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_word", out_word, 32'd0);
        chk("reset_out_beats", {26'b0, out_beats}, 32'd0);
        chk("reset_out_dup", {31'b0, out_dup}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef LZC_ORDER_CHECK_EN
        chk("reset_order_err", {31'b0, out_order_err}, 32'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].n; k++) beat(tbl[i].idx[k*6 +: 6], k == tbl[i].n - 1);
            chk({tbl[i].name, "_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tbl[i].name, "_word"}, out_word, tbl[i].word);
            chk({tbl[i].name, "_beats"}, {26'b0, out_beats}, {26'b0, tbl[i].beats});
            chk({tbl[i].name, "_dup"}, {31'b0, out_dup}, {31'b0, tbl[i].dup});
`ifdef LZC_ORDER_CHECK_EN
            chk({tbl[i].name, "_order_err"}, {31'b0, out_order_err}, {31'b0, tbl[i].err});
`endif
        end
        @(posedge clk);
        #1;
        chk("drain_valid_low", {31'b0, out_valid}, 32'd0);

        // Backpressure: pending word must hold while the next last beat waits.
        out_ready = 1'b0;
        beat(6'd0, 1'b1);
        in_valid = 1'b1;
        in_idx   = 6'd1;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_word", out_word, 32'h8000_0000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_word", out_word, 32'h4000_0000);
        chk("b2b_beats", {26'b0, out_beats}, 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_drain", {31'b0, out_valid}, 32'd0);

        // Beat counter saturates at 63.
        for (int k = 0; k < 70; k++) beat(6'd32, k == 69);
        chk("sat_beats", {26'b0, out_beats}, 32'd63);
        chk("sat_word", out_word, 32'd0);
        chk("sat_dup", {31'b0, out_dup}, 32'd0);

        // Reset mid-word discards the partial accumulator.
        beat(6'd2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_beats", {26'b0, out_beats}, 32'd0);
        beat(6'd4, 1'b1);
        chk("rst_after_word", out_word, 32'h0800_0000);
        chk("rst_after_beats", {26'b0, out_beats}, 32'd1);
        chk("rst_after_dup", {31'b0, out_dup}, 32'd0);
`ifdef LZC_ORDER_CHECK_EN
        chk("rst_after_order_err", {31'b0, out_order_err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
